// File: rtl/led_mode_sequencer_pkg.sv
// rtl/led_mode_sequencer_pkg.sv - mode encodings and counter sizing shared by the LED sequencer
package led_mode_sequencer_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_mode_sequencer_button_debounce.sv
// rtl/led_mode_sequencer_button_debounce.sv - button synchroniser, debouncer and press edge detect
module button_debounce
  import led_mode_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BUT,
  output logic PRESS,
  output logic PRESS_NEXT
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_deb;
  logic                   r_deb_d;
  logic                   r_press;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], BUT};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= '0;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      r_press <= PRESS_NEXT;
      if (w_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Exposed so the mode FSM can advance on the same edge that raises PRESS.
  assign PRESS_NEXT = r_deb_d & ~r_deb;
  assign PRESS      = r_press;

endmodule

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - push-button driven LED mode FSM with slow/fast blink timer
module led_mode_sequencer
  import led_mode_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES      = 3,
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int SLOW_HALF_PERIOD = 50000000,
  parameter int FAST_HALF_PERIOD = 12500000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BUT,
  output logic              PRESS,
  output logic [MODE_W-1:0] MODE,
  output logic              LED
);

  localparam int            BLINK_MAX = (SLOW_HALF_PERIOD > FAST_HALF_PERIOD) ?
                                        SLOW_HALF_PERIOD : FAST_HALF_PERIOD;
  localparam int            BW        = cnt_width(BLINK_MAX);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF_PERIOD - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF_PERIOD - 1);

  mode_e         r_mode;
  mode_e         w_mode_next;
  logic [BW-1:0] r_cnt;
  logic [BW-1:0] w_cnt_next;
  logic          r_led_n;
  logic          w_lit;
  logic          w_lit_next;
  logic          w_press_next;

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BUT       (BUT),
    .PRESS     (PRESS),
    .PRESS_NEXT(w_press_next)
  );

  assign w_lit = ~r_led_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode  <= MODE_OFF;
      r_cnt   <= '0;
      r_led_n <= 1'b1;
    end else begin
      r_mode  <= w_mode_next;
      r_cnt   <= w_cnt_next;
      r_led_n <= ~w_lit_next;
    end
  end

  // A press outranks a blink toggle: every blink mode starts with a full lit half-period.
  always_comb begin
    w_mode_next = r_mode;
    w_cnt_next  = r_cnt;
    w_lit_next  = w_lit;
    if (w_press_next) begin
      case (r_mode)
        MODE_OFF:  w_mode_next = MODE_ON;
        MODE_ON:   w_mode_next = MODE_SLOW;
        MODE_SLOW: w_mode_next = MODE_FAST;
        default:   w_mode_next = MODE_OFF;
      endcase
      w_cnt_next = '0;
      w_lit_next = (w_mode_next != MODE_OFF);
    end else begin
      case (r_mode)
        MODE_OFF: begin
          w_cnt_next = '0;
          w_lit_next = 1'b0;
        end
        MODE_ON: begin
          w_cnt_next = '0;
          w_lit_next = 1'b1;
        end
        MODE_SLOW: begin
          if (r_cnt == SLOW_LAST) begin
            w_cnt_next = '0;
            w_lit_next = ~w_lit;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == FAST_LAST) begin
            w_cnt_next = '0;
            w_lit_next = ~w_lit;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign MODE = r_mode;
  assign LED  = r_led_n;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - scoreboard bench for the LED mode sequencer with short timings
module tb_led_mode_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int SLOW = 8;
  localparam int FAST = 2;
  localparam int LAT  = SYNC + DEB + 1;

  typedef struct {
    int         edge_n;
    logic [1:0] mode;
    logic       led;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       BUT;
  logic       PRESS;
  logic [1:0] MODE;
  logic       LED;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         rd_idx = 0;
  int         last_edge = 0;
  logic [1:0] exp_mode = 2'd0;
  ev_t        exp_q[$];
  ev_t        obs_q[$];

  led_mode_sequencer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .SLOW_HALF_PERIOD(SLOW),
    .FAST_HALF_PERIOD(FAST)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .BUT  (BUT),
    .PRESS(PRESS),
    .MODE (MODE),
    .LED  (LED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (PRESS === 1'b1) begin
      ev_t o;
      o.edge_n = cyc;
      o.mode   = MODE;
      o.led    = LED;
      obs_q.push_back(o);
    end
  end

  task automatic do_press(input int hold, input int rel);
    ev_t e;
    @(negedge CLK);
    BUT      = 1'b0;
    exp_mode = exp_mode + 2'd1;
    e.edge_n = cyc + LAT;
    e.mode   = exp_mode;
    e.led    = (exp_mode == 2'd0);
    exp_q.push_back(e);
    repeat (hold) @(negedge CLK);
    BUT = 1'b1;
    repeat (rel) @(negedge CLK);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N    = 1'b1;
    exp_mode = 2'd0;
    rd_idx   = obs_q.size();
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    BUT   = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({PRESS, MODE, LED} !== 4'b0001)
      $display("FAIL reset_active: PRESS=%b MODE=%0d LED=%b, want 0 0 1", PRESS, MODE, LED);
    else n_pass++;
    RST_N = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({PRESS, MODE, LED} !== 4'b0001)
        $display("FAIL reset_hold cyc %0d: PRESS=%b MODE=%0d LED=%b, want 0 0 1", i, PRESS, MODE, LED);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    ev_t e;
    ev_t o;
    do_press(30, 15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL hold_press: strobe missing, want edge %0d", e.edge_n);
      else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o.edge_n !== e.edge_n || o.mode !== e.mode || o.led !== e.led)
          $display("FAIL hold_press: edge %0d mode %0d led %b, want %0d %0d %b",
                   o.edge_n, o.mode, o.led, e.edge_n, e.mode, e.led);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != rd_idx) $display("FAIL hold_extra: %0d extra strobes, want 0", obs_q.size() - rd_idx);
    else n_pass++;
    n_checks++;
    if (MODE !== 2'd1 || LED !== 1'b0) $display("FAIL hold_state: MODE=%0d LED=%b, want 1 0", MODE, LED);
    else n_pass++;
  endtask

  task automatic test_glitch();
    ev_t e;
    ev_t o;
    @(negedge CLK);
    BUT = 1'b0;
    repeat (3) @(negedge CLK);
    BUT = 1'b1;
    repeat (20) @(negedge CLK);
    n_checks++;
    if (obs_q.size() != rd_idx || MODE !== 2'd1)
      $display("FAIL glitch_3: strobes %0d MODE=%0d, want 0 1", obs_q.size() - rd_idx, MODE);
    else n_pass++;
    do_press(6, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL glitch_6: strobe missing, want edge %0d", e.edge_n);
      else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o.edge_n !== e.edge_n || o.mode !== e.mode || o.led !== e.led)
          $display("FAIL glitch_6: edge %0d mode %0d led %b, want %0d %0d %b",
                   o.edge_n, o.mode, o.led, e.edge_n, e.mode, e.led);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != rd_idx) $display("FAIL glitch_extra: %0d extra strobes, want 0", obs_q.size() - rd_idx);
    else n_pass++;
  endtask

  task automatic test_blink();
    ev_t  e;
    ev_t  o;
    logic exp_led;
    pulse_reset();
    for (int p = 0; p < 3; p++) begin
      do_press(10, 12);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rd_idx >= obs_q.size()) $display("FAIL blink_press%0d: strobe missing, want edge %0d", p, e.edge_n);
        else begin
          o = obs_q[rd_idx]; rd_idx++;
          last_edge = o.edge_n;
          if (o.edge_n !== e.edge_n || o.mode !== e.mode || o.led !== e.led)
            $display("FAIL blink_press%0d: edge %0d mode %0d led %b, want %0d %0d %b",
                     p, o.edge_n, o.mode, o.led, e.edge_n, e.mode, e.led);
          else n_pass++;
        end
      end
      if (p >= 1) begin
        for (int i = 0; i < 40; i++) begin
          @(negedge CLK);
          exp_led = (((cyc - last_edge) / ((p == 1) ? SLOW : FAST)) % 2) != 0;
          n_checks++;
          if (LED !== exp_led || MODE !== exp_mode)
            $display("FAIL blink_mode%0d cyc %0d: LED=%b MODE=%0d, want %b %0d",
                     exp_mode, cyc, LED, MODE, exp_led, exp_mode);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_wrap();
    ev_t e;
    ev_t o;
    for (int p = 0; p < 2; p++) begin
      do_press(10, 12);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rd_idx >= obs_q.size()) $display("FAIL wrap_press%0d: strobe missing, want edge %0d", p, e.edge_n);
        else begin
          o = obs_q[rd_idx]; rd_idx++;
          if (o.edge_n !== e.edge_n || o.mode !== e.mode || o.led !== e.led)
            $display("FAIL wrap_press%0d: edge %0d mode %0d led %b, want %0d %0d %b",
                     p, o.edge_n, o.mode, o.led, e.edge_n, e.mode, e.led);
          else n_pass++;
        end
      end
      n_checks++;
      if (MODE !== exp_mode || LED !== (exp_mode == 2'd0))
        $display("FAIL wrap_state%0d: MODE=%0d LED=%b, want %0d %b", p, MODE, LED, exp_mode, exp_mode == 2'd0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    ev_t e;
    ev_t o;
    do_press(10, 5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL mid_setup: strobe missing, want edge %0d", e.edge_n);
      else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o.edge_n !== e.edge_n || o.mode !== e.mode)
          $display("FAIL mid_setup: edge %0d mode %0d, want %0d %0d", o.edge_n, o.mode, e.edge_n, e.mode);
        else n_pass++;
      end
    end
    @(negedge CLK);
    BUT   = 1'b0;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (MODE !== 2'd0 || LED !== 1'b1 || PRESS !== 1'b0)
      $display("FAIL mid_async: MODE=%0d LED=%b PRESS=%b, want 0 1 0", MODE, LED, PRESS);
    else n_pass++;
    repeat (3) @(negedge CLK);
    RST_N    = 1'b1;
    exp_mode = 2'd1;
    e.edge_n = cyc + LAT;
    e.mode   = 2'd1;
    e.led    = 1'b0;
    exp_q.push_back(e);
    repeat (20) @(negedge CLK);
    BUT = 1'b1;
    repeat (12) @(negedge CLK);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL mid_press: strobe missing, want edge %0d", e.edge_n);
      else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o.edge_n !== e.edge_n || o.mode !== e.mode || o.led !== e.led)
          $display("FAIL mid_press: edge %0d mode %0d led %b, want %0d %0d %b",
                   o.edge_n, o.mode, o.led, e.edge_n, e.mode, e.led);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != rd_idx || MODE !== 2'd1)
      $display("FAIL mid_extra: extra %0d MODE=%0d, want 0 1", obs_q.size() - rd_idx, MODE);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_glitch();
    test_blink();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
